cache_scoreboard: RTL and testbench
===================================

CACHE_SCOREBOARD -- requirements
Module: cache_scoreboard

Interface
REQ-001 The module SHALL have parameter DATA_W, default 32, meaning the CPU data word width in bits.
REQ-002 The module SHALL have parameter ADDR_W, default 20, meaning the CPU byte-address width.
REQ-003 The module SHALL have parameter SHADOW_AW, default 10, meaning the shadow-memory word-index width; the index is req_addr[SHADOW_AW+1:2].
REQ-004 The module SHALL have parameter DEPTH, default 8, meaning the number of entries in the expected-data FIFO; DEPTH SHALL be a power of two and at least 2.
REQ-005 The module SHALL have parameter CNT_W, default 16, meaning the width of the statistics counters.
REQ-006 The module SHALL have one clock and a reset that is synchronous and active-low; the ports SHALL be named clk and rst.
REQ-007 The module SHALL have the following ports (name, direction, width, meaning):
  - clk  in  1  clock.
  - rst  in  1  synchronous active-low reset.
  - req_valid  in  1  CPU request valid.
  - req_rw  in  1  1 = write, 0 = read.
  - req_addr  in  ADDR_W  CPU byte address.
  - req_data  in  DATA_W  write data.
  - cpu_stopped  in  1  cache stall; while high, no request is accepted.
  - rsp_ready  in  1  cache returns read data this cycle.
  - rsp_data  in  DATA_W  returned read data.
  - clear  in  1  synchronous clear of counters, flags and first-error capture.
  - rd_count, wr_count, err_count  out  CNT_W each  accepted reads, accepted writes, mismatches.
  - err_flag  out  1  sticky, set on the first mismatch.
  - first_err_addr, first_err_exp, first_err_got  out  ADDR_W, DATA_W, DATA_W  capture of the first mismatch.
  - overflow, underflow  out  1 each  sticky FIFO error flags.
  - outstanding  out  $clog2(DEPTH)+1  reads awaiting a response.
  - idle  out  1  high when outstanding == 0.

Function
REQ-008 A request SHALL be accepted when req_valid && !cpu_stopped; a write and a read are never accepted in the same cycle.
REQ-009 On an accepted write, the module SHALL store req_data into shadow[index] at that clock edge and set the written bit for that index.
REQ-010 On an accepted read, the module SHALL push {req_addr, shadow[index], written[index]} into the FIFO at the same edge; the shadow read is combinational.
REQ-011 A read accepted in the cycle after a write to the same index SHALL expect the newly written data.
REQ-012 On rsp_ready, the module SHALL pop the oldest entry. If that entry's written bit is 0, the compare is skipped (don't-care). Otherwise the module SHALL compare the entry's data with rsp_data.
REQ-013 Bypass: when the FIFO is empty and a push and rsp_ready occur in the same cycle, the module SHALL compare rsp_data against the entry being pushed; that entry is not stored and outstanding is unchanged.
REQ-014 When the FIFO is non-empty and a push and a pop occur in the same cycle, both SHALL take effect and outstanding SHALL be unchanged.
REQ-015 On a mismatch, err_count SHALL increment. If err_flag is 0, the module SHALL set err_flag and capture the entry's address, its expected data and rsp_data; later mismatches SHALL NOT overwrite the capture.
REQ-016 Overflow: a push into a full FIFO with no simultaneous pop SHALL be dropped and SHALL set overflow; rd_count still increments.
REQ-017 Underflow: rsp_ready with an empty FIFO and no push SHALL set underflow and perform no compare.
REQ-018 All counters SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-019 The FIFO read and write pointers SHALL wrap modulo DEPTH; full is outstanding == DEPTH.
REQ-020 clear SHALL zero the counters, err_flag, the capture registers, overflow and underflow. clear SHALL NOT affect the FIFO or the shadow memory. An event in the same cycle as clear is discarded.
REQ-021 The compare and update registers SHALL be visible on the outputs one cycle after the rsp_ready edge.

Reset
REQ-022 While rst == 0 at a clock edge, the module SHALL zero all counters, flags, capture registers, FIFO pointers, outstanding and all written bits, and SHALL set idle = 1.
REQ-023 Shadow data SHALL NOT be reset. Reset mid-operation SHALL discard all outstanding entries, and a subsequent rsp_ready SHALL set underflow.

Verification
REQ-024 Write 0xDEADBEEF to 0x00010, then read 0x00010, then rsp_ready with 0xDEADBEEF -> err_count = 0, wr_count = 1, rd_count = 1, idle = 1.
REQ-025 Read of a never-written address, then rsp_ready with 0x12345678 -> err_count = 0 (don't-care entry).
REQ-026 Write 0xA5A5A5A5 to 0x00020, read it, then respond 0x5A5A5A5A; a second bad read follows -> err_count = 2, first_err_addr = 0x00020, first_err_exp = 0xA5A5A5A5, first_err_got = 0x5A5A5A5A.
REQ-027 DEPTH+1 reads with no responses -> outstanding = DEPTH, overflow = 1; then DEPTH responses -> outstanding = 0, underflow = 0.
REQ-028 Empty FIFO with a read accepted and rsp_ready in the same cycle (bypass) -> compare performed, outstanding stays 0. rsp_ready on an empty FIFO with no read -> underflow = 1.
REQ-029 cpu_stopped held high during req_valid -> no count changes. rst low mid-stream with 3 outstanding -> outstanding = 0 on the next cycle.

Source files
------------

// File: rtl/cache_scoreboard.sv
// -----------------------------------------------------------------------------
// cache_scoreboard
//
// Checks a cache against a shadow copy of memory. CPU writes update a
// word-indexed shadow RAM. Each CPU read captures the address, the shadow data
// and a "was ever written" bit into an in-order FIFO. When the cache returns
// read data, the oldest entry is popped and compared. Entries for words that
// were never written are don't-care. Mismatches, FIFO misuse and traffic are
// counted and flagged for inspection.
//
// Ports
//   clk, rst          clock, synchronous active-low reset
//   req_valid/req_rw  CPU request strobe, 1 = write / 0 = read
//   req_addr/req_data CPU byte address and write data
//   cpu_stopped       cache stall, blocks request acceptance
//   rsp_ready/rsp_data cache read-data return
//   clear             zero statistics, flags and first-error capture
//   rd_count, wr_count, err_count   saturating statistics
//   err_flag, first_err_*           sticky first-mismatch capture
//   overflow, underflow             sticky FIFO misuse flags
//   outstanding, idle               reads awaiting a response
// -----------------------------------------------------------------------------
module cache_scoreboard #(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 20,
   parameter int SHADOW_AW = 10,
   parameter int DEPTH     = 8,
   parameter int CNT_W     = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    req_valid,
   input  logic                    req_rw,
   input  logic [ADDR_W-1:0]       req_addr,
   input  logic [DATA_W-1:0]       req_data,
   input  logic                    cpu_stopped,
   input  logic                    rsp_ready,
   input  logic [DATA_W-1:0]       rsp_data,
   input  logic                    clear,
   output logic [CNT_W-1:0]        rd_count,
   output logic [CNT_W-1:0]        wr_count,
   output logic [CNT_W-1:0]        err_count,
   output logic                    err_flag,
   output logic [ADDR_W-1:0]       first_err_addr,
   output logic [DATA_W-1:0]       first_err_exp,
   output logic [DATA_W-1:0]       first_err_got,
   output logic                    overflow,
   output logic                    underflow,
   output logic [$clog2(DEPTH):0]  outstanding,
   output logic                    idle
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int OUT_W = PTR_W + 1;
   localparam int WORDS = 1 << SHADOW_AW;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic              wr;    // 0 = word never written, compare skipped
   } entry_t;

   logic [DATA_W-1:0]    shadow [WORDS];
   logic [WORDS-1:0]     written;
   entry_t               fifo_mem [DEPTH];
   logic [PTR_W-1:0]     wr_ptr;
   logic [PTR_W-1:0]     rd_ptr;

   logic [SHADOW_AW-1:0] idx;
   logic                 accept_wr;
   logic                 accept_rd;
   logic                 empty;
   logic                 full;
   logic                 bypass;
   logic                 pop;
   logic                 store;
   logic                 overflow_evt;
   logic                 underflow_evt;
   entry_t               push_entry;
   entry_t               cmp_entry;
   logic                 mismatch;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   assign idx       = req_addr[SHADOW_AW+1:2];
   assign accept_wr = req_valid && !cpu_stopped &&  req_rw;
   assign accept_rd = req_valid && !cpu_stopped && !req_rw;

   // Shadow read is combinational, so a read right after a write sees the
   // data stored at the previous edge.
   assign push_entry = '{addr: req_addr, data: shadow[idx], wr: written[idx]};

   assign empty = (outstanding == '0);
   assign full  = (outstanding == OUT_W'(DEPTH));
   assign idle  = empty;

   // Empty FIFO with a read and a response in the same cycle: the response
   // belongs to this very read, so compare directly and never store it.
   assign bypass        = empty && accept_rd && rsp_ready;
   assign pop           = rsp_ready && !empty;
   assign store         = accept_rd && !bypass && (!full || pop);
   assign overflow_evt  = accept_rd && full && !pop;
   assign underflow_evt = rsp_ready && empty && !accept_rd;

   assign cmp_entry = bypass ? push_entry : fifo_mem[rd_ptr];
   assign mismatch  = (bypass || pop) && cmp_entry.wr && (cmp_entry.data != rsp_data);

   // NOTE: storage arrays carry no reset; only the written bits and pointers
   // decide whether their contents are meaningful, so memories infer cleanly.
   always_ff @(posedge clk) begin
      if (accept_wr) shadow[idx] <= req_data;
      if (store)     fifo_mem[wr_ptr] <= push_entry;
   end

   // NOTE: all state updates use non-blocking assignments so every register
   // samples the pre-edge values computed above, independent of block order.
   always_ff @(posedge clk) begin
      if (!rst) begin
         written     <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         outstanding <= '0;
      end else begin
         if (accept_wr) written[idx] <= 1'b1;
         // Pointer width equals log2(DEPTH), so increment wraps modulo DEPTH.
         if (store) wr_ptr <= wr_ptr + 1'b1;
         if (pop)   rd_ptr <= rd_ptr + 1'b1;
         if (store && !pop)      outstanding <= outstanding + 1'b1;
         else if (pop && !store) outstanding <= outstanding - 1'b1;
      end
   end

   // Statistics and sticky flags. clear wins over any event in its cycle;
   // the FIFO and shadow keep operating underneath.
   always_ff @(posedge clk) begin
      if (!rst || clear) begin
         rd_count       <= '0;
         wr_count       <= '0;
         err_count      <= '0;
         err_flag       <= 1'b0;
         first_err_addr <= '0;
         first_err_exp  <= '0;
         first_err_got  <= '0;
         overflow       <= 1'b0;
         underflow      <= 1'b0;
      end else begin
         if (accept_rd) rd_count <= sat_inc(rd_count);
         if (accept_wr) wr_count <= sat_inc(wr_count);
         if (mismatch) begin
            err_count <= sat_inc(err_count);
            if (!err_flag) begin
               err_flag       <= 1'b1;
               first_err_addr <= cmp_entry.addr;
               first_err_exp  <= cmp_entry.data;
               first_err_got  <= rsp_data;
            end
         end
         if (overflow_evt)  overflow  <= 1'b1;
         if (underflow_evt) underflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_cache_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_cache_scoreboard
//
// Drives cache_scoreboard with a directed vector table, hand-written corner
// sequences and a random phase. A behavioural model (shadow map plus a queue
// of expected read entries) predicts every output after each clock.
// -----------------------------------------------------------------------------
module tb_cache_scoreboard;

   localparam int DW    = 32;
   localparam int AW    = 20;
   localparam int SAW   = 10;
   localparam int DEPTH = 8;
   localparam int CW    = 4;    // narrow counters so saturation is reachable
   localparam int OW    = $clog2(DEPTH) + 1;

   logic           clk = 1'b0;
   logic           rst;
   logic           req_valid;
   logic           req_rw;
   logic [AW-1:0]  req_addr;
   logic [DW-1:0]  req_data;
   logic           cpu_stopped;
   logic           rsp_ready;
   logic [DW-1:0]  rsp_data;
   logic           clear;
   logic [CW-1:0]  rd_count;
   logic [CW-1:0]  wr_count;
   logic [CW-1:0]  err_count;
   logic           err_flag;
   logic [AW-1:0]  first_err_addr;
   logic [DW-1:0]  first_err_exp;
   logic [DW-1:0]  first_err_got;
   logic           overflow;
   logic           underflow;
   logic [OW-1:0]  outstanding;
   logic           idle;

   always #5 clk = ~clk;

   cache_scoreboard #(
      .DATA_W(DW), .ADDR_W(AW), .SHADOW_AW(SAW), .DEPTH(DEPTH), .CNT_W(CW)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_rw(req_rw), .req_addr(req_addr),
      .req_data(req_data), .cpu_stopped(cpu_stopped),
      .rsp_ready(rsp_ready), .rsp_data(rsp_data), .clear(clear),
      .rd_count(rd_count), .wr_count(wr_count), .err_count(err_count),
      .err_flag(err_flag), .first_err_addr(first_err_addr),
      .first_err_exp(first_err_exp), .first_err_got(first_err_got),
      .overflow(overflow), .underflow(underflow),
      .outstanding(outstanding), .idle(idle)
   );

   // ---------------------------------------------------------------- model
   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic          wr;
   } ent_t;

   ent_t          exp_q[$];
   logic [DW-1:0] m_shadow[int];
   int            m_rd, m_wr, m_err;
   logic          m_flag, m_ovf, m_unf;
   logic [AW-1:0] m_fa;
   logic [DW-1:0] m_fe, m_fg;

   int n_vec  = 0;
   int n_miss = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      n_vec++;
      if (got !== want) begin
         n_miss++;
         $display("FAIL %s: got %0h, want %0h", name, got, want);
      end
   endtask

   function automatic int sat(input int v);
      return (v == (1 << CW) - 1) ? v : v + 1;
   endfunction

   task automatic model_reset();
      exp_q.delete();
      m_shadow.delete();
      m_rd = 0; m_wr = 0; m_err = 0;
      m_flag = 0; m_ovf = 0; m_unf = 0;
      m_fa = '0; m_fe = '0; m_fg = '0;
   endtask

   task automatic model_step(input logic v, input logic rw, input logic [AW-1:0] a,
                             input logic [DW-1:0] d, input logic stp, input logic rsp,
                             input logic [DW-1:0] rdat, input logic clr);
      int   ix;
      int   sz;
      logic acc, wr, rd, byp, popped, cmp, mis, ovf, unf;
      ent_t ne, ce;
      ix     = int'(a[SAW+1:2]);
      acc    = v && !stp;
      wr     = acc && rw;
      rd     = acc && !rw;
      ne.addr = a;
      ne.wr   = m_shadow.exists(ix);
      ne.data = ne.wr ? m_shadow[ix] : '0;
      sz     = exp_q.size();
      byp    = (sz == 0) && rd && rsp;
      popped = rsp && (sz > 0);
      cmp    = 0;
      ce     = ne;
      if (byp) cmp = ne.wr;
      else if (popped) begin
         ce  = exp_q.pop_front();
         cmp = ce.wr;
      end
      mis = cmp && (ce.data != rdat);
      ovf = rd && !byp && (sz == DEPTH) && !popped;
      unf = rsp && (sz == 0) && !rd;
      if (rd && !byp && !ovf) exp_q.push_back(ne);
      if (wr) m_shadow[ix] = d;
      if (clr) begin
         m_rd = 0; m_wr = 0; m_err = 0;
         m_flag = 0; m_ovf = 0; m_unf = 0;
         m_fa = '0; m_fe = '0; m_fg = '0;
      end else begin
         if (rd) m_rd = sat(m_rd);
         if (wr) m_wr = sat(m_wr);
         if (mis) begin
            m_err = sat(m_err);
            if (!m_flag) begin
               m_flag = 1; m_fa = ce.addr; m_fe = ce.data; m_fg = rdat;
            end
         end
         if (ovf) m_ovf = 1;
         if (unf) m_unf = 1;
      end
   endtask

   task automatic compare_all();
      check("rd_count",       rd_count,       m_rd);
      check("wr_count",       wr_count,       m_wr);
      check("err_count",      err_count,      m_err);
      check("err_flag",       err_flag,       m_flag);
      check("first_err_addr", first_err_addr, m_fa);
      check("first_err_exp",  first_err_exp,  m_fe);
      check("first_err_got",  first_err_got,  m_fg);
      check("overflow",       overflow,       m_ovf);
      check("underflow",      underflow,      m_unf);
      check("outstanding",    outstanding,    exp_q.size());
      check("idle",           idle,           exp_q.size() == 0);
   endtask

   task automatic idle_inputs();
      req_valid = 0; req_rw = 0; req_addr = '0; req_data = '0;
      cpu_stopped = 0; rsp_ready = 0; rsp_data = '0; clear = 0;
   endtask

   // One clock: drive, predict, clock, sample 1 ns after the edge, compare.
   task automatic step(input logic v, input logic rw, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic stp, input logic rsp,
                       input logic [DW-1:0] rdat, input logic clr);
      req_valid = v; req_rw = rw; req_addr = a; req_data = d;
      cpu_stopped = stp; rsp_ready = rsp; rsp_data = rdat; clear = clr;
      model_step(v, rw, a, d, stp, rsp, rdat, clr);
      @(posedge clk);
      #1;
      compare_all();
      idle_inputs();
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      model_reset();
      compare_all();
   endtask

   task automatic rd(input logic [AW-1:0] a);
      step(1, 0, a, '0, 0, 0, '0, 0);
   endtask
   task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
      step(1, 1, a, d, 0, 0, '0, 0);
   endtask
   task automatic rsp(input logic [DW-1:0] d);
      step(0, 0, '0, '0, 0, 1, d, 0);
   endtask
   task automatic clr();
      step(0, 0, '0, '0, 0, 0, '0, 1);
   endtask

   // ---------------------------------------------------------- vector table
   typedef struct {
      logic          v, rw;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic          stp, rsp;
      logic [DW-1:0] rdat;
      logic          clr;
      int            e_rd, e_wr, e_err, e_out;
      logic          e_flag;
      logic [AW-1:0] e_fa;
      logic [DW-1:0] e_fe, e_fg;
   } vec_t;

   localparam int NV = 18;
   vec_t vec [NV];

   initial begin
      // v rw addr  data          stp rsp rdat         clr  rd wr er out flag fa  fe            fg
      vec[0]  = '{1,1,'h10,32'hDEADBEEF,0,0,32'h0,       0,  0,1,0,0, 0,'h0, 32'h0,        32'h0};
      vec[1]  = '{1,0,'h10,32'h0,       0,0,32'h0,       0,  1,1,0,1, 0,'h0, 32'h0,        32'h0};
      vec[2]  = '{0,0,'h0, 32'h0,       0,1,32'hDEADBEEF,0,  1,1,0,0, 0,'h0, 32'h0,        32'h0};
      vec[3]  = '{1,0,'h40,32'h0,       0,0,32'h0,       0,  2,1,0,1, 0,'h0, 32'h0,        32'h0};
      vec[4]  = '{0,0,'h0, 32'h0,       0,1,32'h12345678,0,  2,1,0,0, 0,'h0, 32'h0,        32'h0};
      vec[5]  = '{1,1,'h20,32'hA5A5A5A5,0,0,32'h0,       0,  2,2,0,0, 0,'h0, 32'h0,        32'h0};
      vec[6]  = '{1,0,'h20,32'h0,       0,0,32'h0,       0,  3,2,0,1, 0,'h0, 32'h0,        32'h0};
      vec[7]  = '{0,0,'h0, 32'h0,       0,1,32'h5A5A5A5A,0,  3,2,1,0, 1,'h20,32'hA5A5A5A5,32'h5A5A5A5A};
      vec[8]  = '{1,0,'h20,32'h0,       0,0,32'h0,       0,  4,2,1,1, 1,'h20,32'hA5A5A5A5,32'h5A5A5A5A};
      vec[9]  = '{0,0,'h0, 32'h0,       0,1,32'h0,       0,  4,2,2,0, 1,'h20,32'hA5A5A5A5,32'h5A5A5A5A};
      vec[10] = '{1,0,'h10,32'h0,       0,1,32'hDEADBEEF,0,  5,2,2,0, 1,'h20,32'hA5A5A5A5,32'h5A5A5A5A};
      vec[11] = '{1,0,'h10,32'h0,       0,1,32'h0,       0,  6,2,3,0, 1,'h20,32'hA5A5A5A5,32'h5A5A5A5A};
      vec[12] = '{0,0,'h0, 32'h0,       0,1,32'h0,       0,  6,2,3,0, 1,'h20,32'hA5A5A5A5,32'h5A5A5A5A};
      vec[13] = '{1,1,'h10,32'hFFFFFFFF,1,0,32'h0,       0,  6,2,3,0, 1,'h20,32'hA5A5A5A5,32'h5A5A5A5A};
      vec[14] = '{1,1,'h30,32'h111,     0,0,32'h0,       0,  6,3,3,0, 1,'h20,32'hA5A5A5A5,32'h5A5A5A5A};
      vec[15] = '{1,0,'h30,32'h0,       0,0,32'h0,       0,  7,3,3,1, 1,'h20,32'hA5A5A5A5,32'h5A5A5A5A};
      vec[16] = '{0,0,'h0, 32'h0,       0,1,32'h111,     0,  7,3,3,0, 1,'h20,32'hA5A5A5A5,32'h5A5A5A5A};
      vec[17] = '{0,0,'h0, 32'h0,       0,0,32'h0,       1,  0,0,0,0, 0,'h0, 32'h0,        32'h0};

      idle_inputs();
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      do_reset();
      check("reset_idle", idle, 1'b1);

      for (int i = 0; i < NV; i++) begin
         step(vec[i].v, vec[i].rw, vec[i].addr, vec[i].data,
              vec[i].stp, vec[i].rsp, vec[i].rdat, vec[i].clr);
         check($sformatf("v%0d_rd", i),   rd_count,       vec[i].e_rd);
         check($sformatf("v%0d_wr", i),   wr_count,       vec[i].e_wr);
         check($sformatf("v%0d_err", i),  err_count,      vec[i].e_err);
         check($sformatf("v%0d_out", i),  outstanding,    vec[i].e_out);
         check($sformatf("v%0d_flag", i), err_flag,       vec[i].e_flag);
         check($sformatf("v%0d_fa", i),   first_err_addr, vec[i].e_fa);
         check($sformatf("v%0d_fe", i),   first_err_exp,  vec[i].e_fe);
         check($sformatf("v%0d_fg", i),   first_err_got,  vec[i].e_fg);
         if (i == 12) check("v12_underflow", underflow, 1'b1);
      end

      // Overflow: DEPTH+1 reads, then DEPTH good responses.
      for (int i = 0; i <= DEPTH; i++) rd('h20);
      check("ovf_outstanding", outstanding, DEPTH);
      check("ovf_flag",        overflow,    1'b1);
      check("ovf_rd_count",    rd_count,    DEPTH + 1);
      for (int i = 0; i < DEPTH; i++) rsp(32'hA5A5A5A5);
      check("drain_outstanding", outstanding, 0);
      check("drain_underflow",   underflow,   1'b0);
      check("drain_err",         err_count,   0);

      // Full FIFO with simultaneous push and pop: no overflow, depth holds.
      clr();
      for (int i = 0; i < DEPTH; i++) rd('h20);
      step(1, 0, 'h20, '0, 0, 1, 32'hA5A5A5A5, 0);
      check("fullpp_outstanding", outstanding, DEPTH);
      check("fullpp_overflow",    overflow,    1'b0);
      for (int i = 0; i < DEPTH; i++) rsp(32'hA5A5A5A5);
      check("fullpp_drain", outstanding, 0);

      // Non-empty push and pop in the same cycle.
      rd('h10);
      step(1, 0, 'h10, '0, 0, 1, 32'hDEADBEEF, 0);
      check("pp_outstanding", outstanding, 1);
      rsp(32'hDEADBEEF);

      // Counter saturation.
      clr();
      for (int i = 0; i < (1 << CW) + 4; i++) wr('h50, 32'(i));
      check("wr_saturate", wr_count, (1 << CW) - 1);

      // Reset mid-stream with three outstanding reads.
      clr();
      rd('h10); rd('h20); rd('h30);
      check("pre_rst_outstanding", outstanding, 3);
      do_reset();
      check("rst_outstanding", outstanding, 0);
      check("rst_idle",        idle,        1'b1);
      rsp(32'h0);
      check("rst_underflow",   underflow,   1'b1);

      // Random traffic against the model.
      for (int n = 0; n < 400; n++) begin
         logic          v, rw, stp, rr, cl;
         logic [AW-1:0] a;
         logic [DW-1:0] d, rdat;
         int            ix;
         v   = ($urandom_range(1) == 1);
         rw  = ($urandom_range(2) == 0);
         stp = ($urandom_range(7) == 0);
         rr  = ($urandom_range(1) == 1);
         cl  = ($urandom_range(63) == 0);
         a   = AW'($urandom_range(15) * 4) | AW'($urandom_range(3) << 12);
         d   = $urandom;
         ix  = int'(a[SAW+1:2]);
         if (exp_q.size() > 0)       rdat = exp_q[0].data;
         else if (m_shadow.exists(ix)) rdat = m_shadow[ix];
         else                         rdat = $urandom;
         if ($urandom_range(3) == 0) rdat = rdat ^ DW'($urandom_range(255) + 1);
         step(v, rw, a, d, stp, rr, rdat, cl);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
